// File: rtl/cfg_manager.sv
// Control/status register file written by the CPU over the BRAM-style bus (select SEL_CONFIG).
// Define CFG_READBACK_EN for full register readback; default build reads back only status and VERSION.
module cfg_manager #(
    parameter logic [15:0] VERSION    = 16'h0001,
    parameter logic [1:0]  SEL_CONFIG = 2'd0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        BUS_EN,
    input  logic        BUS_WE,
    input  logic [1:0]  BRAM_SELECT,
    input  logic [13:0] BRAM_ADDR,
    input  logic [15:0] DATA_IN,
    output logic [15:0] DATA_OUT,
    input  logic        THERMO,
    output logic        MOD_CLK_INIT,
    output logic        SEQ_CLK_INIT,
    output logic [15:0] MOD_CLK_CYCLE,
    output logic [15:0] MOD_CLK_DIV,
    output logic [15:0] SEQ_CLK_CYCLE,
    output logic [15:0] SEQ_CLK_DIV,
    output logic [63:0] SYNC0_TIME,
    output logic [15:0] WAVELENGTH,
    output logic [15:0] SEQ_ADDR_OFFSET,
    output logic [15:0] MOD_ADDR_OFFSET,
    output logic        SEQ_MODE,
    output logic        SEQ_DATA_MODE,
    output logic        SILENT,
    output logic        FORCE_FAN,
    output logic        OUTPUT_EN,
    output logic        OUTPUT_BALANCE
);

`ifdef CFG_READBACK_EN
    localparam int CTRL_W = 15;
`else
    // CTRL bits 14:6 have no consumer without readback, so only the live bits are kept.
    localparam int CTRL_W = 6;
`endif

    logic              strb_meta;
    logic              strb_sync;
    logic              armed;
    logic [1:0]        warm;
    logic              commit;
    logic              init_pulse;
    logic [CTRL_W-1:0] ctrl;
    logic [15:0]       rd_data;

    // armed only sets once a synchronised low is seen after the pipeline has refilled,
    // so a strobe already high when reset releases never commits.
    always_ff @(posedge CLK) begin
        if (RST) begin
            strb_meta <= 1'b0;
            strb_sync <= 1'b0;
            armed     <= 1'b0;
            warm      <= '0;
        end else begin
            strb_meta <= BUS_EN & BUS_WE;
            strb_sync <= strb_meta;
            warm      <= {warm[0], 1'b1};
            if (strb_sync)
                armed <= 1'b0;
            else if (warm[1])
                armed <= 1'b1;
        end
    end

    assign commit = strb_sync & armed & (BRAM_SELECT == SEL_CONFIG);

    always_ff @(posedge CLK) begin
        if (RST) begin
            ctrl            <= '0;
            init_pulse      <= 1'b0;
            SEQ_CLK_CYCLE   <= '0;
            SEQ_CLK_DIV     <= '0;
            MOD_CLK_CYCLE   <= '0;
            MOD_CLK_DIV     <= '0;
            MOD_ADDR_OFFSET <= '0;
            SEQ_ADDR_OFFSET <= '0;
            WAVELENGTH      <= '0;
            SYNC0_TIME      <= '0;
        end else begin
            init_pulse <= 1'b0;
            if (commit) begin
                case (BRAM_ADDR)
                    14'h00: begin
                        ctrl       <= DATA_IN[CTRL_W-1:0];
                        init_pulse <= DATA_IN[15];
                    end
                    14'h02: SEQ_CLK_CYCLE     <= DATA_IN;
                    14'h03: SEQ_CLK_DIV       <= DATA_IN;
                    14'h04: MOD_CLK_CYCLE     <= DATA_IN;
                    14'h05: MOD_CLK_DIV       <= DATA_IN;
                    14'h06: MOD_ADDR_OFFSET   <= DATA_IN;
                    14'h07: SEQ_ADDR_OFFSET   <= DATA_IN;
                    14'h08: WAVELENGTH        <= DATA_IN;
                    14'h09: SYNC0_TIME[15:0]  <= DATA_IN;
                    14'h0A: SYNC0_TIME[31:16] <= DATA_IN;
                    14'h0B: SYNC0_TIME[47:32] <= DATA_IN;
                    14'h0C: SYNC0_TIME[63:48] <= DATA_IN;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (BRAM_ADDR)
            14'h01: rd_data = {15'b0, THERMO};
            14'h3F: rd_data = VERSION;
`ifdef CFG_READBACK_EN
            14'h00: rd_data = {1'b0, ctrl};
            14'h02: rd_data = SEQ_CLK_CYCLE;
            14'h03: rd_data = SEQ_CLK_DIV;
            14'h04: rd_data = MOD_CLK_CYCLE;
            14'h05: rd_data = MOD_CLK_DIV;
            14'h06: rd_data = MOD_ADDR_OFFSET;
            14'h07: rd_data = SEQ_ADDR_OFFSET;
            14'h08: rd_data = WAVELENGTH;
            14'h09: rd_data = SYNC0_TIME[15:0];
            14'h0A: rd_data = SYNC0_TIME[31:16];
            14'h0B: rd_data = SYNC0_TIME[47:32];
            14'h0C: rd_data = SYNC0_TIME[63:48];
`endif
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST)
            DATA_OUT <= '0;
        else
            DATA_OUT <= (BRAM_SELECT == SEL_CONFIG) ? rd_data : '0;
    end

    assign OUTPUT_EN      = ctrl[0];
    assign OUTPUT_BALANCE = ctrl[1];
    assign SILENT         = ctrl[2];
    assign FORCE_FAN      = ctrl[3];
    assign SEQ_MODE       = ctrl[4];
    assign SEQ_DATA_MODE  = ctrl[5];
    assign MOD_CLK_INIT   = init_pulse;
    assign SEQ_CLK_INIT   = init_pulse;

endmodule

// File: tb/tb_cfg_manager.sv
// Scoreboard bench for cfg_manager: a bench-side register model queues expectations, drained after each transaction.
module tb_cfg_manager;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        BUS_EN = 1'b0;
    logic        BUS_WE = 1'b0;
    logic [1:0]  BRAM_SELECT = 2'd0;
    logic [13:0] BRAM_ADDR = '0;
    logic [15:0] DATA_IN = '0;
    logic [15:0] DATA_OUT;
    logic        THERMO = 1'b0;
    logic        MOD_CLK_INIT, SEQ_CLK_INIT;
    logic [15:0] MOD_CLK_CYCLE, MOD_CLK_DIV, SEQ_CLK_CYCLE, SEQ_CLK_DIV;
    logic [63:0] SYNC0_TIME;
    logic [15:0] WAVELENGTH, SEQ_ADDR_OFFSET, MOD_ADDR_OFFSET;
    logic        SEQ_MODE, SEQ_DATA_MODE, SILENT, FORCE_FAN, OUTPUT_EN, OUTPUT_BALANCE;

    cfg_manager #(.VERSION(16'h0001), .SEL_CONFIG(2'd0)) dut (
        .CLK(CLK), .RST(RST), .BUS_EN(BUS_EN), .BUS_WE(BUS_WE),
        .BRAM_SELECT(BRAM_SELECT), .BRAM_ADDR(BRAM_ADDR), .DATA_IN(DATA_IN),
        .DATA_OUT(DATA_OUT), .THERMO(THERMO),
        .MOD_CLK_INIT(MOD_CLK_INIT), .SEQ_CLK_INIT(SEQ_CLK_INIT),
        .MOD_CLK_CYCLE(MOD_CLK_CYCLE), .MOD_CLK_DIV(MOD_CLK_DIV),
        .SEQ_CLK_CYCLE(SEQ_CLK_CYCLE), .SEQ_CLK_DIV(SEQ_CLK_DIV),
        .SYNC0_TIME(SYNC0_TIME), .WAVELENGTH(WAVELENGTH),
        .SEQ_ADDR_OFFSET(SEQ_ADDR_OFFSET), .MOD_ADDR_OFFSET(MOD_ADDR_OFFSET),
        .SEQ_MODE(SEQ_MODE), .SEQ_DATA_MODE(SEQ_DATA_MODE), .SILENT(SILENT),
        .FORCE_FAN(FORCE_FAN), .OUTPUT_EN(OUTPUT_EN), .OUTPUT_BALANCE(OUTPUT_BALANCE)
    );

    always #5 CLK = ~CLK;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;
    int unsigned mod_hi = 0;
    int unsigned seq_hi = 0;
    int unsigned mod_mark = 0;
    int unsigned seq_mark = 0;

    logic [15:0] model [0:12];
    string       tag_q [$];
    int          id_q  [$];
    logic [63:0] exp_q [$];

    // Cycles high, so a stretched pulse counts more than once.
    always @(posedge CLK) begin
        if (MOD_CLK_INIT) mod_hi <= mod_hi + 1;
        if (SEQ_CLK_INIT) seq_hi <= seq_hi + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        if (obs === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] get_obs(input int id);
        case (id)
            0:  return {48'b0, WAVELENGTH};
            1:  return {48'b0, SEQ_ADDR_OFFSET};
            2:  return {48'b0, SEQ_CLK_CYCLE};
            3:  return {48'b0, SEQ_CLK_DIV};
            4:  return {48'b0, MOD_CLK_CYCLE};
            5:  return {48'b0, MOD_CLK_DIV};
            6:  return {48'b0, MOD_ADDR_OFFSET};
            7:  return SYNC0_TIME;
            8:  return {58'b0, SEQ_DATA_MODE, SEQ_MODE, FORCE_FAN, SILENT, OUTPUT_BALANCE, OUTPUT_EN};
            9:  return {48'b0, DATA_OUT};
            10: return 64'(mod_hi - mod_mark);
            11: return 64'(seq_hi - seq_mark);
            default: return '1;
        endcase
    endfunction

    task automatic push(input string tag, input int id, input logic [63:0] exp);
        tag_q.push_back(tag);
        id_q.push_back(id);
        exp_q.push_back(exp);
    endtask

    task automatic drain();
        @(negedge CLK);
        while (id_q.size() > 0)
            check_val(tag_q.pop_front(), get_obs(id_q.pop_front()), exp_q.pop_front());
    endtask

    task automatic push_outputs(input string pfx);
        push({pfx, "_wavelength"}, 0, {48'b0, model[8]});
        push({pfx, "_seq_off"},    1, {48'b0, model[7]});
        push({pfx, "_seq_cycle"},  2, {48'b0, model[2]});
        push({pfx, "_seq_div"},    3, {48'b0, model[3]});
        push({pfx, "_mod_cycle"},  4, {48'b0, model[4]});
        push({pfx, "_mod_div"},    5, {48'b0, model[5]});
        push({pfx, "_mod_off"},    6, {48'b0, model[6]});
        push({pfx, "_sync0"},      7, {model[12], model[11], model[10], model[9]});
        push({pfx, "_ctrl_bits"},  8, {58'b0, model[0][5:0]});
    endtask

    function automatic logic [15:0] exp_read(input logic [13:0] addr);
        if (addr == 14'h01) return {15'b0, THERMO};
        if (addr == 14'h3F) return 16'h0001;
`ifdef CFG_READBACK_EN
        if (addr <= 14'h0C) return model[addr[3:0]];
`endif
        return 16'h0000;
    endfunction

    task automatic bus_write(input logic [1:0] sel, input logic [13:0] addr, input logic [15:0] data);
        BRAM_SELECT = sel;
        BRAM_ADDR   = addr;
        DATA_IN     = data;
        #3;
        BUS_EN = 1'b1;
        BUS_WE = 1'b1;
        #70;
        BUS_EN = 1'b0;
        BUS_WE = 1'b0;
        #40;
        if (sel == 2'd0) begin
            if (addr == 14'h00) model[0] = data & 16'h7FFF;
            else if (addr >= 14'h02 && addr <= 14'h0C) model[addr[3:0]] = data;
        end
    endtask

    task automatic bus_read(input string tag, input logic [1:0] sel, input logic [13:0] addr);
        BRAM_SELECT = sel;
        BRAM_ADDR   = addr;
        push(tag, 9, (sel == 2'd0) ? {48'b0, exp_read(addr)} : 64'h0);
        repeat (2) @(posedge CLK);
        drain();
    endtask

    task automatic mark_pulses();
        mod_mark = mod_hi;
        seq_mark = seq_hi;
    endtask

    logic [13:0] wr_addr [0:7] = '{14'h08, 14'h07, 14'h02, 14'h03, 14'h04, 14'h05, 14'h06, 14'h0D};
    logic [15:0] wr_data [0:7] = '{16'd8500, 16'd0, 16'd1, 16'd1, 16'h0123, 16'h0007, 16'hBEEF, 16'hDEAD};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i <= 12; i++) model[i] = '0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        repeat (4) @(posedge CLK);

        bus_read("rd_version", 2'd0, 14'h3F);
        push_outputs("reset");
        drain();
        bus_read("rd_status_cold", 2'd0, 14'h01);
        THERMO = 1'b1;
        bus_read("rd_status_hot", 2'd0, 14'h01);

        mark_pulses();
        for (int i = 0; i < 8; i++) bus_write(2'd0, wr_addr[i], wr_data[i]);
        push_outputs("cfg");
        push("cfg_no_mod_init", 10, 64'd0);
        drain();
        bus_read("rd_wavelength", 2'd0, 14'h08);

        bus_write(2'd0, 14'h09, 16'hA120);
        bus_write(2'd0, 14'h0A, 16'h0007);
        bus_write(2'd0, 14'h0B, 16'h0000);
        bus_write(2'd0, 14'h0C, 16'h0000);
        mark_pulses();
        bus_write(2'd0, 14'h00, 16'h8010);
        push_outputs("init");
        push("init_sync0_value", 7, 64'd500000);
        push("init_mod_pulse", 10, 64'd1);
        push("init_seq_pulse", 11, 64'd1);
        drain();
        bus_read("rd_ctrl_init", 2'd0, 14'h00);
        bus_read("rd_sync0_lo", 2'd0, 14'h09);

        mark_pulses();
        bus_write(2'd0, 14'h00, 16'h0030);
        push_outputs("raw_mode");
        push("raw_mode_no_pulse", 10, 64'd0);
        drain();
        bus_write(2'd0, 14'h00, 16'h000F);
        push_outputs("static");
        push("static_no_pulse", 11, 64'd0);
        drain();

        mark_pulses();
        bus_write(2'd0, 14'h00, 16'h800F);
        bus_write(2'd0, 14'h00, 16'hC00F);
        push_outputs("b2b");
        push("b2b_mod_pulses", 10, 64'd2);
        push("b2b_seq_pulses", 11, 64'd2);
        drain();
        bus_read("rd_ctrl_hi", 2'd0, 14'h00);

        bus_write(2'd3, 14'h008, 16'h1234);
        bus_write(2'd1, 14'h000, 16'h0000);
        push_outputs("other_sel");
        drain();
        bus_read("rd_other_sel", 2'd3, 14'h3F);
        bus_read("rd_unmapped", 2'd0, 14'h20);

        mark_pulses();
        BRAM_SELECT = 2'd0;
        BRAM_ADDR   = 14'h08;
        DATA_IN     = 16'h5555;
        #3;
        BUS_EN = 1'b1;
        BUS_WE = 1'b1;
        #4 RST = 1'b1;
        #30 RST = 1'b0;
        #60;
        BUS_EN = 1'b0;
        BUS_WE = 1'b0;
        #40;
        for (int i = 0; i <= 12; i++) model[i] = '0;
        push_outputs("rst_abort");
        push("rst_abort_no_pulse", 10, 64'd0);
        drain();
        bus_read("rd_wl_after_rst", 2'd0, 14'h08);
        bus_read("rd_version_after_rst", 2'd0, 14'h3F);

        bus_write(2'd0, 14'h08, 16'h4242);
        push_outputs("post_rst_write");
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
